// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction and queue-state definitions for the snake input path
// Contents: direction codes DIR_XP/DIR_XM/DIR_YP/DIR_YM, queue FSM state type,
//           helpers for the axis partner of a direction and lowest-index press selection.
package snake_pkg;

    localparam logic [1:0] DIR_XP = 2'b00;
    localparam logic [1:0] DIR_XM = 2'b01;
    localparam logic [1:0] DIR_YP = 2'b10;
    localparam logic [1:0] DIR_YM = 2'b11;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'b00,
        Q_ONE   = 2'b01,
        Q_TWO   = 2'b10
    } q_state_t;

    // Directions on the same axis differ only in bit 0, so flipping it gives the reversal.
    function automatic logic [1:0] reverse_of(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

    // Button index equals its direction code; the lowest set bit wins.
    function automatic logic [1:0] pick_lowest(input logic [3:0] r);
        logic [1:0] idx;
        idx = DIR_YM;
        if (r[2]) idx = DIR_YP;
        if (r[1]) idx = DIR_XM;
        if (r[0]) idx = DIR_XP;
        return idx;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 4-bit button synchronizer plus shared debounce counter
// Ports: clock, reset (async active-low), restart (sync clear), buttons[3:0] raw in,
//        btn_db[3:0] debounced vector out.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart,
    input  logic [3:0] buttons,
    output logic [3:0] btn_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  sync_out;
    logic [3:0]                  sync_prev;
    logic [CNT_W-1:0]            cnt;
    logic [3:0]                  btn_db_q;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign btn_db   = btn_db_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            sync_prev <= '0;
            cnt       <= '0;
            btn_db_q  <= '0;
        end else if (restart) begin
            sync_q    <= '0;
            sync_prev <= '0;
            cnt       <= '0;
            btn_db_q  <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], buttons};
            sync_prev <= sync_out;
            if (sync_out != sync_prev) begin
                cnt <= '0;
            end else begin
                // Saturate so a long hold does not wrap and re-trigger.
                if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                // cnt counts stable cycles minus one; the final stable cycle commits.
                if (cnt >= CNT_LAST) btn_db_q <= sync_out;
            end
        end
    end

endmodule

// File: rtl/direction_input_ctrl.sv
// rtl/direction_input_ctrl.sv - snake button front end: press detect, reversal reject, turn queue
// Ports: clock, reset (async active-low), restart (sync clear), buttons[3:0] raw,
//        consume (pop pulse), direction[1:0], pending, played (press pulse), db_state[1:0].
// Build option: DIR_BUFFER_EN enables the second queue entry (state TWO).
module direction_input_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart,
    input  logic [3:0] buttons,
    input  logic       consume,
    output logic [1:0] direction,
    output logic       pending,
    output logic       played,
    output logic [1:0] db_state
);

    logic [3:0] btn_db;
    logic [3:0] btn_db_prev;
    logic [3:0] rise;
    logic       any_rise;
    logic [1:0] cand;
    logic [1:0] ref_dir;
    logic       accept;

    q_state_t   state, state_next;
    logic [1:0] dir_q, dir_next;
    logic [1:0] head_q, head_next;
    logic [1:0] tail_q, tail_next;
    logic       played_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_debouncer (
        .clock  (clock),
        .reset  (reset),
        .restart(restart),
        .buttons(buttons),
        .btn_db (btn_db)
    );

    assign rise     = btn_db & ~btn_db_prev;
    assign any_rise = |rise;
    assign cand     = pick_lowest(rise);

    // Compare against the most recent intended heading, not the one on screen.
    always_comb begin
        ref_dir = dir_q;
        if (state == Q_ONE) ref_dir = head_q;
        if (state == Q_TWO) ref_dir = tail_q;
    end

    assign accept = any_rise && (cand != ref_dir) && (cand != reverse_of(ref_dir));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= Q_EMPTY;
            dir_q       <= DIR_XP;
            head_q      <= DIR_XP;
            tail_q      <= DIR_XP;
            btn_db_prev <= '0;
            played_q    <= 1'b0;
        end else if (restart) begin
            state       <= Q_EMPTY;
            dir_q       <= DIR_XP;
            head_q      <= DIR_XP;
            tail_q      <= DIR_XP;
            btn_db_prev <= '0;
            played_q    <= 1'b0;
        end else begin
            state       <= state_next;
            dir_q       <= dir_next;
            head_q      <= head_next;
            tail_q      <= tail_next;
            btn_db_prev <= btn_db;
            played_q    <= any_rise;
        end
    end

    // Pop is applied before push whenever both happen on the same edge.
    always_comb begin
        state_next = state;
        dir_next   = dir_q;
        head_next  = head_q;
        tail_next  = tail_q;
        case (state)
            Q_EMPTY: begin
                if (accept) begin
                    head_next  = cand;
                    state_next = Q_ONE;
                end
            end
            Q_ONE: begin
                if (consume) begin
                    dir_next = head_q;
                    if (accept) head_next = cand;
                    else        state_next = Q_EMPTY;
                end else if (accept) begin
`ifdef DIR_BUFFER_EN
                    tail_next  = cand;
                    state_next = Q_TWO;
`else
                    head_next  = cand;
`endif
                end
            end
            Q_TWO: begin
                if (consume) begin
                    dir_next  = head_q;
                    head_next = tail_q;
                    if (accept) tail_next = cand;
                    else        state_next = Q_ONE;
                end else if (accept) begin
                    tail_next = cand;
                end
            end
            default: begin
                state_next = Q_EMPTY;
            end
        endcase
    end

    assign direction = dir_q;
    assign pending   = (state != Q_EMPTY);
    assign played    = played_q;
    assign db_state  = state;

endmodule
